poseidon_req_arbiter: RTL
=========================

Name: poseidon_req_arbiter

Overview:
- Shares one PoseidonTopLevel hash core among NUM_REQ requesters.
- Grants the core input stream to one requester per packet, round-robin, and forwards that requester's beats until `last`.
- Records the granted requester ID in an in-order tag FIFO.
- Steers each core output packet back to the requester at the FIFO head; the core returns packets in input order.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 255, payload width in bits of one field element.
- TAG_DEPTH, 4, maximum packets granted but not yet fully returned (power of 2).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester input valid.
- req_ready  out  NUM_REQ  per-requester input ready.
- req_last  in  NUM_REQ  per-requester last beat of packet.
- req_payload  in  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- core_in_valid  out  1  to core io_input_valid.
- core_in_ready  in  1  from core io_input_ready.
- core_in_last  out  1  to core io_input_last.
- core_in_payload  out  DATA_W  to core io_input_payload.
- core_out_valid  in  1  from core io_output_valid.
- core_out_ready  out  1  to core io_output_ready.
- core_out_last  in  1  from core io_output_last.
- core_out_payload  in  DATA_W  from core io_output_payload.
- rsp_valid  out  NUM_REQ  one-hot response valid.
- rsp_ready  in  NUM_REQ  per-requester response ready.
- rsp_last  out  1  broadcast; qualified by rsp_valid.
- rsp_payload  out  DATA_W  broadcast; qualified by rsp_valid.
- busy  out  1  high when the FSM is in GRANT or outstanding != 0.
- outstanding  out  clog2(TAG_DEPTH+1)  current tag FIFO occupancy.

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE; tag FIFO is emptied (outstanding = 0).
  - last_grant = NUM_REQ-1, so the first grant after reset goes to requester 0.
  - All req_ready, core_in_valid, core_out_ready and rsp_valid are 0 during reset and in the cycle after it.
- Reset mid-packet: partial packets are abandoned, not completed. The core shares the same reset.
- Input FSM, IDLE:
  - Grant condition: any req_valid and outstanding < TAG_DEPTH.
  - Grantee g is the first requester with req_valid, searching upward cyclically from last_grant+1 (wrap at NUM_REQ).
  - At the clock edge: grant <= g, push g into the tag FIFO, go to GRANT.
  - In IDLE: core_in_valid = 0 and all req_ready = 0.
  - If the FIFO is full, no grant is made; stay in IDLE.
- Input FSM, GRANT:
  - core_in_valid = req_valid[grant]; core_in_last = req_last[grant]; core_in_payload = slice grant.
  - req_ready[grant] = core_in_ready; all other req_ready = 0. This path is purely combinational (zero latency).
  - On a handshake with core_in_last = 1: last_grant <= grant, go to IDLE.
  - Result: at least one idle cycle between consecutive packets.
- Requester rule: a requester must not drop valid mid-packet. A requester with valid low in GRANT simply stalls the core input.
- Output steering, tag FIFO empty:
  - core_out_ready = 0; all rsp_valid = 0.
  - core_out_valid while empty is a protocol error; the beat is held, not dropped.
- Output steering, FIFO non-empty with head h:
  - rsp_valid[h] = core_out_valid; all other rsp_valid = 0.
  - core_out_ready = rsp_ready[h]; rsp_last/rsp_payload pass through combinationally.
  - On a handshake with core_out_last = 1: pop the FIFO.
- FIFO boundaries:
  - Simultaneous push (grant) and pop (last response): outstanding unchanged.
  - Push is never attempted when full; pop is never attempted when empty.
  - Pointers wrap modulo TAG_DEPTH.
- Ordering: responses leave strictly in grant order, independent of requester index.

Test Plan:
- Single requester: req 2 sends a 3-beat packet A,B,C (last on C), core_in_ready=1. Required: grant one cycle after req_valid; core_in carries A,B,C in 3 consecutive cycles; outstanding=1. The core response is returned with rsp_valid=4'b0100 only; outstanding=0 after rsp_last.
- Round-robin: all 4 requesters continuously valid, 1-beat packets. Required: grant order 0,1,2,3,0,... with one idle cycle between packets.
- FIFO full: hold core_out_ready path blocked (rsp_ready=0), 5 requests pending. Required: exactly 4 grants, outstanding=4, 5th requester sees req_ready=0 until one pop; then it is granted on the next IDLE cycle.
- Ordered return with backpressure: grants 1 then 3, rsp_ready[1] low for 6 cycles. Required: core_out_ready=0 for those cycles; the packet for 3 is not delivered before 1's packet completes.
- Simultaneous push/pop: a last response handshake in the same cycle as a new grant with outstanding=2. Required: outstanding stays 2; head advances; new tag is appended.
- Reset mid-packet: assert reset during beat 2 of a 3-beat grant. Required: next cycle IDLE, outstanding=0, busy=0, all ready/valid outputs 0; the first subsequent grant goes to the lowest valid requester starting from 0.

Source files
------------

// File: rtl/poseidon_req_arbiter.sv
// Round-robin packet arbiter that shares one Poseidon hash core among NUM_REQ requesters.
// An in-order tag FIFO steers each core response packet back to the requester that sent it.
module poseidon_req_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 255,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0]                 req_last,
  input  logic [NUM_REQ*DATA_W-1:0]          req_payload,
  output logic                               core_in_valid,
  input  logic                               core_in_ready,
  output logic                               core_in_last,
  output logic [DATA_W-1:0]                  core_in_payload,
  input  logic                               core_out_valid,
  output logic                               core_out_ready,
  input  logic                               core_out_last,
  input  logic [DATA_W-1:0]                  core_out_payload,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  input  logic [NUM_REQ-1:0]                 rsp_ready,
  output logic                               rsp_last,
  output logic [DATA_W-1:0]                  rsp_payload,
  output logic                               busy,
  output logic [$clog2(TAG_DEPTH+1)-1:0]     outstanding
);

  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(TAG_DEPTH + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [ID_W-1:0]  tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [ID_W-1:0]  rr_pick;
  logic [ID_W-1:0]  head;
  logic             rr_found;
  logic             fifo_empty, fifo_full;
  logic             push, pop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(TAG_DEPTH));
  assign head       = tag_mem[rd_ptr_q];

  // Round-robin search: smallest cyclic offset above last_grant wins.
  always_comb begin
    int idx;
    idx      = 0;
    rr_pick  = '0;
    rr_found = 1'b0;
    for (int off = int'(NUM_REQ); off > 0; off--) begin
      idx = (int'(last_grant_q) + off) % int'(NUM_REQ);
      if (req_valid[idx]) begin
        rr_pick  = ID_W'(idx);
        rr_found = 1'b1;
      end
    end
  end

  // Input FSM next-state and core input path.
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_grant_d    = last_grant_q;
    push            = 1'b0;
    req_ready       = '0;
    core_in_valid   = 1'b0;
    core_in_last    = 1'b0;
    core_in_payload = req_payload[int'(grant_q) * int'(DATA_W) +: DATA_W];
    case (state_q)
      IDLE: begin
        if (rr_found && !fifo_full) begin
          push    = 1'b1;
          grant_d = rr_pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        core_in_valid      = req_valid[grant_q];
        core_in_last       = req_last[grant_q];
        req_ready[grant_q] = core_in_ready;
        if (req_valid[grant_q] && core_in_ready && req_last[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      req_ready     = '0;
      core_in_valid = 1'b0;
      push          = 1'b0;
    end
  end

  // Response steering to the requester at the tag FIFO head.
  always_comb begin
    rsp_valid      = '0;
    core_out_ready = 1'b0;
    if (!fifo_empty && !reset) begin
      rsp_valid[head] = core_out_valid;
      core_out_ready  = rsp_ready[head];
    end
  end

  assign pop         = core_out_valid && core_out_ready && core_out_last;
  assign rsp_last    = core_out_last;
  assign rsp_payload = core_out_payload;
  assign busy        = (state_q == GRANT) || !fifo_empty;
  assign outstanding = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PTR_W'(TAG_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(TAG_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Tag storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr_q] <= rr_pick;
    end
  end

endmodule
